// File: rtl/dct_idct_seq_pkg.sv
// Shared definitions for the DCT -> approximate-IDCT frame sequencer:
// sequencer state encoding and default block geometry.
package dct_idct_seq_pkg;

  localparam int BLK_SAMPLES_DEF = 64;
  localparam int CNT_W_DEF       = 16;
  localparam int BLK_LOG2        = $clog2(BLK_SAMPLES_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/dct_seq_blk_counter.sv
// Sample counter with block counter. The sample count either wraps modulo
// BLK_SAMPLES (input side) or saturates at BLK_SAMPLES until cleared
// (output side). The block count advances once per completed block.
module dct_seq_blk_counter
  import dct_idct_seq_pkg::*;
#(
  parameter int BLK_SAMPLES = BLK_SAMPLES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SAMP_W      = BLK_LOG2 + 1,
  parameter bit SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_all,
  input  logic             clr_samp,
  input  logic             inc,
  output logic             room,
  output logic             wrap,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(BLK_SAMPLES - 1);
  localparam logic [SAMP_W-1:0] SAMP_FULL = SAMP_W'(BLK_SAMPLES);
  localparam logic [SAMP_W-1:0] SAMP_ONE  = SAMP_W'(1);
  localparam logic [CNT_W-1:0]  BLK_ONE   = CNT_W'(1);

  logic [SAMP_W-1:0] samp_cnt_reg;
  logic [CNT_W-1:0]  blk_cnt_reg;

  // A saturating counter refuses further samples once the block is full;
  // a wrapping counter always has room.
  generate
    if (SATURATE) begin : g_sat
      assign room = (samp_cnt_reg < SAMP_FULL);
    end else begin : g_wrap
      assign room = 1'b1;
    end
  endgenerate

  assign wrap    = inc && room && (samp_cnt_reg == SAMP_LAST);
  assign blk_cnt = blk_cnt_reg;

  // Sample and block count registers.
  always_ff @(posedge clk) begin
    if (reset || clr_all) begin
      samp_cnt_reg <= '0;
      blk_cnt_reg  <= '0;
    end else begin
      if (clr_samp) begin
        samp_cnt_reg <= '0;
      end else if (inc && room) begin
        samp_cnt_reg <= (wrap && !SATURATE) ? '0 : samp_cnt_reg + SAMP_ONE;
      end
      if (wrap) begin
        blk_cnt_reg <= blk_cnt_reg + BLK_ONE;
      end
    end
  end

endmodule

// File: rtl/dct_idct_seq_ctrl.sv
// Frame sequencer for an 8x8 DCT -> approximate-IDCT chain: gates the DCT
// start, paces sample loads, frames IDCT output into blocks and drives the
// IDCT precision selects from a programmable block window.
// Optional drain watchdog: define DCT_IDCT_SEQ_WATCHDOG_EN.
module dct_idct_seq_ctrl
  import dct_idct_seq_pkg::*;
#(
  parameter int BLK_SAMPLES = BLK_SAMPLES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WD_CYCLES   = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic [CNT_W-1:0] apx_lo,
  input  logic [CNT_W-1:0] apx_hi,
  input  logic             src_valid,
  input  logic             reading,
  input  logic             done_dct,
  input  logic             done_idct,
  output logic             start_dct,
  output logic             racc,
  output logic             rapx,
  output logic             load_sample,
  output logic             dout_valid,
  output logic [CNT_W-1:0] blk_out,
  output logic             busy,
  output logic             all_done,
  output logic             timeout
);

  localparam int SAMP_W = $clog2(BLK_SAMPLES) + 1;
  localparam logic [CNT_W-1:0] BLK_ONE = CNT_W'(1);

  seq_state_t state_reg, state_next;
  logic [CNT_W-1:0] num_lat_reg;
  logic             start_dct_reg, start_dct_next;
  logic             racc_reg, racc_next;
  logic             done_dct_q_reg;
  logic [CNT_W-1:0] dct_blk_reg;
  logic             rapx_reg;

  logic             active;
  logic             frame_start;
  logic             dct_rise;
  logic             wd_fire;
  logic             in_wrap;
  logic [CNT_W-1:0] in_blk;
  logic             in_room_unused;
  logic             out_room;
  logic             out_wrap_unused;

  assign active      = (state_reg == RUN) || (state_reg == DRAIN);
  assign frame_start = (state_reg == IDLE) && go;
  assign dct_rise    = active && done_dct && !done_dct_q_reg;

  assign load_sample = (state_reg == RUN) && reading && src_valid;
  assign dout_valid  = active && done_idct && out_room;

  assign start_dct = start_dct_reg;
  assign racc      = racc_reg;
  assign rapx      = rapx_reg;
  assign busy      = active;
  assign all_done  = (state_reg == DONE);

  dct_seq_blk_counter #(
    .BLK_SAMPLES(BLK_SAMPLES),
    .CNT_W      (CNT_W),
    .SAMP_W     (SAMP_W),
    .SATURATE   (1'b0)
  ) u_in_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_all (frame_start),
    .clr_samp(1'b0),
    .inc     (load_sample),
    .room    (in_room_unused),
    .wrap    (in_wrap),
    .blk_cnt (in_blk)
  );

  // Output framing: a long done_idct phase yields exactly one block.
  dct_seq_blk_counter #(
    .BLK_SAMPLES(BLK_SAMPLES),
    .CNT_W      (CNT_W),
    .SAMP_W     (SAMP_W),
    .SATURATE   (1'b1)
  ) u_out_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_all (frame_start),
    .clr_samp(!done_idct),
    .inc     (dout_valid),
    .room    (out_room),
    .wrap    (out_wrap_unused),
    .blk_cnt (blk_out)
  );

`ifdef DCT_IDCT_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_reg;

  assign wd_fire = (state_reg == DRAIN) && !dout_valid && (wd_cnt_reg == WD_LAST);
  assign timeout = timeout_reg;

  // Drain idle-cycle counter; any output sample proves the IDCT is alive.
  always_ff @(posedge clk) begin
    if (reset || (state_reg != DRAIN) || dout_valid) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + WD_ONE;
    end
  end

  // Timeout flag stays up through DONE and clears on return to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_reg <= 1'b0;
    end else if (wd_fire) begin
      timeout_reg <= 1'b1;
    end else if (state_next == IDLE) begin
      timeout_reg <= 1'b0;
    end
  end
`else
  // Limit is kept in the parameter list so both builds share one interface.
  localparam int WD_CYCLES_UNUSED = WD_CYCLES;
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state logic plus the registered DCT start and accurate-path reset.
  always_comb begin
    state_next     = state_reg;
    racc_next      = racc_reg;
    start_dct_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next = (num_blocks == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // The load that completes the last block ends the input phase.
        if (in_wrap && ((in_blk + BLK_ONE) == num_lat_reg)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (blk_out == num_lat_reg) begin
          state_next = DONE;
        end else if (wd_fire) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!go) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    start_dct_next = (state_next == RUN);
    if (state_next == IDLE) begin
      racc_next = 1'b1;
    end else if (state_next == RUN) begin
      racc_next = 1'b0;
    end
  end

  // State and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      start_dct_reg <= 1'b0;
      racc_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      start_dct_reg <= start_dct_next;
      racc_reg      <= racc_next;
    end
  end

  // Block count for the frame, captured as the frame starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_lat_reg <= '0;
    end else if (frame_start) begin
      num_lat_reg <= num_blocks;
    end
  end

  // DCT block index and approximate-mode select, updated per done_dct rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_dct_q_reg <= 1'b0;
      dct_blk_reg    <= '0;
      rapx_reg       <= 1'b0;
    end else begin
      done_dct_q_reg <= done_dct;
      if (frame_start) begin
        dct_blk_reg <= '0;
      end else if (dct_rise) begin
        dct_blk_reg <= dct_blk_reg + BLK_ONE;
        rapx_reg    <= (dct_blk_reg >= apx_lo) && (dct_blk_reg < apx_hi);
      end
    end
  end

endmodule

// File: tb/tb_dct_idct_seq_ctrl.sv
// Self-checking bench for dct_idct_seq_ctrl. Expectations come from the
// frame-level rules: 64 loads per block, one output block per done_idct
// phase, window membership per DCT block index.
module tb_dct_idct_seq_ctrl;

  localparam int CNT_W = 16;
  localparam int BLK   = 64;
  localparam int WD    = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             go;
  logic [CNT_W-1:0] num_blocks;
  logic [CNT_W-1:0] apx_lo;
  logic [CNT_W-1:0] apx_hi;
  logic             src_valid;
  logic             reading;
  logic             done_dct;
  logic             done_idct;
  logic             start_dct;
  logic             racc;
  logic             rapx;
  logic             load_sample;
  logic             dout_valid;
  logic [CNT_W-1:0] blk_out;
  logic             busy;
  logic             all_done;
  logic             timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dct_idct_seq_ctrl #(
    .BLK_SAMPLES(BLK),
    .CNT_W      (CNT_W),
    .WD_CYCLES  (WD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .num_blocks (num_blocks),
    .apx_lo     (apx_lo),
    .apx_hi     (apx_hi),
    .src_valid  (src_valid),
    .reading    (reading),
    .done_dct   (done_dct),
    .done_idct  (done_idct),
    .start_dct  (start_dct),
    .racc       (racc),
    .rapx       (rapx),
    .load_sample(load_sample),
    .dout_valid (dout_valid),
    .blk_out    (blk_out),
    .busy       (busy),
    .all_done   (all_done),
    .timeout    (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    reset = 1'b1; go = 1'b0; num_blocks = '0; apx_lo = '0; apx_hi = '0;
    src_valid = 1'b0; reading = 1'b0; done_dct = 1'b0; done_idct = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    obs = {start_dct, racc, load_sample, dout_valid, rapx, busy, all_done, timeout};
    checks++;
    if (obs !== 8'b0100_0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 8'b0100_0000);
    end
    checks++;
    if (blk_out !== '0) begin
      errors++; $display("FAIL reset_blk_out: got %0d expected 0", blk_out);
    end
    $display("reset: outputs=%b blk_out=%0d", obs, blk_out);
  endtask

  task automatic start_frame(input int n);
    num_blocks = CNT_W'(n);
    go = 1'b1;
    tick();
    checks++;
    if ({start_dct, racc, busy} !== 3'b101) begin
      errors++; $display("FAIL frame_start: got start/racc/busy=%b expected 101", {start_dct, racc, busy});
    end
  endtask

  // Drives loads until stop_at samples have been accepted; total is the frame size.
  task automatic run_loads(input int total, input int stop_at, input bit rnd);
    int loads = 0;
    int bad = 0;
    int cyc = 0;
    logic exp_load;
    while (loads < stop_at && cyc < 20000) begin
      src_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      reading   = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      #1;
      exp_load = src_valid && reading;
      if (load_sample !== exp_load || start_dct !== 1'b1) bad++;
      if (exp_load) loads++;
      tick();
      cyc++;
    end
    src_valid = 1'b0; reading = 1'b0;
    checks++;
    if (bad != 0 || loads != stop_at) begin
      errors++; $display("FAIL load_pace: loads=%0d bad_cycles=%0d expected loads=%0d bad=0", loads, bad, stop_at);
    end
    if (stop_at == total) begin
      checks++;
      if ({start_dct, busy, all_done} !== 3'b010) begin
        errors++; $display("FAIL enter_drain: got start/busy/done=%b expected 010", {start_dct, busy, all_done});
      end
      src_valid = 1'b1; reading = 1'b1;
      #1;
      checks++;
      if (load_sample !== 1'b0) begin
        errors++; $display("FAIL drain_no_load: got %b expected 0", load_sample);
      end
      src_valid = 1'b0; reading = 1'b0;
    end
    $display("loads: %0d of %0d in %0d cycles", loads, total, cyc);
  endtask

  // One done_idct phase of 'hold' cycles per block.
  task automatic drain_blocks(input int n, input int hold);
    int vcount;
    int exp_v;
    for (int b = 0; b < n; b++) begin
      done_idct = 1'b1;
      vcount = 0;
      for (int c = 0; c < hold; c++) begin
        #1;
        if (dout_valid === 1'b1) vcount++;
        tick();
      end
      done_idct = 1'b0;
      tick(); tick();
      exp_v = (hold < BLK) ? hold : BLK;
      checks++;
      if (vcount != exp_v || blk_out !== CNT_W'(b + 1)) begin
        errors++; $display("FAIL out_block: valid=%0d blk_out=%0d expected valid=%0d blk_out=%0d", vcount, blk_out, exp_v, b + 1);
      end
      $display("out block %0d: hold=%0d valid=%0d blk_out=%0d", b, hold, vcount, blk_out);
    end
    checks++;
    if ({all_done, busy} !== 2'b10) begin
      errors++; $display("FAIL frame_done: got done/busy=%b expected 10", {all_done, busy});
    end
  endtask

  task automatic end_frame();
    go = 1'b0;
    tick();
    checks++;
    if ({all_done, busy, racc} !== 3'b001) begin
      errors++; $display("FAIL back_to_idle: got done/busy/racc=%b expected 001", {all_done, busy, racc});
    end
  endtask

  task automatic test_two_blocks();
    start_frame(2);
    run_loads(128, 128, 1'b0);
    drain_blocks(2, 70);
    end_frame();
  endtask

  task automatic test_rapx(input int lo, input int hi, input int n, input bit rnd);
    logic exp_r;
    apx_lo = CNT_W'(lo); apx_hi = CNT_W'(hi);
    start_frame(n);
    if (rnd) go = 1'b0;
    run_loads(BLK * n, BLK * n, rnd);
    for (int k = 0; k < n; k++) begin
      exp_r = (k >= lo) && (k < hi);
      done_dct = 1'b1;
      tick();
      checks++;
      if (rapx !== exp_r) begin
        errors++; $display("FAIL rapx_edge: block %0d got %b expected %b", k, rapx, exp_r);
      end
      tick(); tick();
      done_dct = 1'b0;
      tick();
      checks++;
      if (rapx !== exp_r) begin
        errors++; $display("FAIL rapx_hold: block %0d got %b expected %b", k, rapx, exp_r);
      end
      $display("dct block %0d: window [%0d,%0d) rapx=%b", k, lo, hi, rapx);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL go_drop_ignored: busy=%b expected 1", busy);
    end
    go = 1'b1;
    drain_blocks(n, $urandom_range(64, 75));
    end_frame();
  endtask

  task automatic test_ignored_in_idle();
    logic r0;
    logic [CNT_W-1:0] b0;
    r0 = rapx; b0 = blk_out;
    apx_lo = '0; apx_hi = '1;
    done_dct = 1'b1; tick(); done_dct = 1'b0; tick();
    checks++;
    if (rapx !== r0) begin
      errors++; $display("FAIL idle_rapx: got %b expected %b", rapx, r0);
    end
    done_idct = 1'b1;
    #1;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++; $display("FAIL idle_dout: got %b expected 0", dout_valid);
    end
    tick(); tick(); tick();
    done_idct = 1'b0;
    checks++;
    if (blk_out !== b0) begin
      errors++; $display("FAIL idle_blk_out: got %0d expected %0d", blk_out, b0);
    end
    $display("idle pulses: rapx=%b blk_out=%0d", rapx, blk_out);
  endtask

  task automatic test_zero_blocks();
    num_blocks = '0; go = 1'b1; src_valid = 1'b1; reading = 1'b1;
    #1;
    checks++;
    if (load_sample !== 1'b0) begin
      errors++; $display("FAIL zero_idle_load: got %b expected 0", load_sample);
    end
    tick();
    checks++;
    if ({all_done, start_dct, load_sample, busy} !== 4'b1000) begin
      errors++; $display("FAIL zero_done: got done/start/load/busy=%b expected 1000", {all_done, start_dct, load_sample, busy});
    end
    src_valid = 1'b0; reading = 1'b0;
    end_frame();
    $display("zero blocks: frame completed without loads");
  endtask

  task automatic test_mid_reset();
    start_frame(2);
    run_loads(128, 30, 1'b0);
    reset = 1'b1; go = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if ({start_dct, busy, racc} !== 3'b001 || blk_out !== '0) begin
      errors++; $display("FAIL mid_reset: got start/busy/racc=%b blk_out=%0d expected 001 and 0", {start_dct, busy, racc}, blk_out);
    end
    start_frame(1);
    run_loads(64, 64, 1'b0);
    drain_blocks(1, 64);
    end_frame();
  endtask

  task automatic test_watchdog();
    int d = 0;
    start_frame(1);
    run_loads(64, 64, 1'b0);
    while (all_done !== 1'b1 && d < 400) begin
      tick();
      d++;
    end
`ifdef DCT_IDCT_SEQ_WATCHDOG_EN
    checks++;
    if (d != WD || timeout !== 1'b1) begin
      errors++; $display("FAIL watchdog_fire: cycles=%0d timeout=%b expected %0d and 1", d, timeout, WD);
    end
    end_frame();
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL watchdog_clear: timeout=%b expected 0", timeout);
    end
`else
    checks++;
    if ({all_done, busy, timeout} !== 3'b010) begin
      errors++; $display("FAIL drain_wait: got done/busy/timeout=%b expected 010", {all_done, busy, timeout});
    end
    drain_blocks(1, 64);
    end_frame();
`endif
    $display("watchdog: drain cycles observed=%0d timeout=%b", d, timeout);
  endtask

  initial begin
    test_reset();
    test_two_blocks();
    test_rapx(1, 3, 4, 1'b0);
    test_ignored_in_idle();
    test_rapx(3, 1, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      test_rapx($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(1, 5), 1'b1);
    end
    test_zero_blocks();
    test_mid_reset();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
